// File: rtl/l2_request_scheduler.sv
// Single-in-flight scheduler that steers decoded trace commands to the L2 cache's L1-side,
// snoop or maintenance request port and keeps saturating per-class statistics.
module l2_request_scheduler #(
    parameter int unsigned addressSize = 32,
    parameter int unsigned STAT_W      = 32,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    input  logic [3:0]             cmd_code,
    input  logic [addressSize-1:0] cmd_addr,
    output logic                   cmd_ready,
    output logic                   l1_req_valid,
    output logic [1:0]             l1_op,
    output logic [addressSize-1:0] l1_addr,
    input  logic                   l1_done,
    output logic                   snp_req_valid,
    output logic [1:0]             snp_op,
    output logic [addressSize-1:0] snp_addr,
    input  logic                   snp_done,
    output logic                   mnt_req_valid,
    output logic                   mnt_op,
    input  logic                   mnt_done,
    output logic                   timeout_pulse,
    output logic [STAT_W-1:0]      l1_count,
    output logic [STAT_W-1:0]      snp_count,
    output logic [STAT_W-1:0]      illegal_count,
    output logic [STAT_W-1:0]      timeout_count
);

    localparam int unsigned TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TMR_LAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        L1_BUSY  = 2'd1,
        SNP_BUSY = 2'd2,
        MNT_BUSY = 2'd3
    } state_e;

    state_e                  state_q,       state_d;
    logic                    l1_valid_q,    l1_valid_d;
    logic [1:0]              l1_op_q,       l1_op_d;
    logic [addressSize-1:0]  l1_addr_q,     l1_addr_d;
    logic                    snp_valid_q,   snp_valid_d;
    logic [1:0]              snp_op_q,      snp_op_d;
    logic [addressSize-1:0]  snp_addr_q,    snp_addr_d;
    logic                    mnt_valid_q,   mnt_valid_d;
    logic                    mnt_op_q,      mnt_op_d;
    logic [TMR_W-1:0]        tmr_q,         tmr_d;
    logic                    to_pulse_q,    to_pulse_d;
    logic [STAT_W-1:0]       l1_cnt_q,      l1_cnt_d;
    logic [STAT_W-1:0]       snp_cnt_q,     snp_cnt_d;
    logic [STAT_W-1:0]       ill_cnt_q,     ill_cnt_d;
    logic [STAT_W-1:0]       to_cnt_q,      to_cnt_d;

    logic                    busy_done_c;
    logic                    limit_hit_c;

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == STAT_MAX) ? v : v + STAT_W'(1);
    endfunction

    // Done only counts when it arrives on the port of the request in flight.
    always_comb begin
        busy_done_c = 1'b0;
        case (state_q)
            L1_BUSY:  busy_done_c = l1_done;
            SNP_BUSY: busy_done_c = snp_done;
            MNT_BUSY: busy_done_c = mnt_done;
            default:  busy_done_c = 1'b0;
        endcase
    end

    assign limit_hit_c = (TIMEOUT != 0) && (tmr_q == TMR_W'(TMR_LAST));

    // Next-state, request payload and statistics update.
    always_comb begin
        state_d     = state_q;
        l1_valid_d  = l1_valid_q;
        l1_op_d     = l1_op_q;
        l1_addr_d   = l1_addr_q;
        snp_valid_d = snp_valid_q;
        snp_op_d    = snp_op_q;
        snp_addr_d  = snp_addr_q;
        mnt_valid_d = mnt_valid_q;
        mnt_op_d    = mnt_op_q;
        tmr_d       = tmr_q;
        to_pulse_d  = 1'b0;
        l1_cnt_d    = l1_cnt_q;
        snp_cnt_d   = snp_cnt_q;
        ill_cnt_d   = ill_cnt_q;
        to_cnt_d    = to_cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_code)
                        4'd0, 4'd1, 4'd2: begin
                            state_d    = L1_BUSY;
                            l1_valid_d = 1'b1;
                            l1_op_d    = cmd_code[1:0];
                            l1_addr_d  = cmd_addr;
                            tmr_d      = '0;
                        end
                        4'd3, 4'd4, 4'd5, 4'd6: begin
                            state_d     = SNP_BUSY;
                            snp_valid_d = 1'b1;
                            snp_op_d    = 2'(cmd_code - 4'd3);
                            snp_addr_d  = cmd_addr;
                            tmr_d       = '0;
                        end
                        4'd8, 4'd9: begin
                            state_d     = MNT_BUSY;
                            mnt_valid_d = 1'b1;
                            mnt_op_d    = cmd_code[0];
                            tmr_d       = '0;
                        end
                        default: ill_cnt_d = sat_inc(ill_cnt_q);
                    endcase
                end
            end
            default: begin
                if (busy_done_c) begin
                    state_d     = IDLE;
                    l1_valid_d  = 1'b0;
                    snp_valid_d = 1'b0;
                    mnt_valid_d = 1'b0;
                    case (state_q)
                        L1_BUSY:  l1_cnt_d  = sat_inc(l1_cnt_q);
                        SNP_BUSY: snp_cnt_d = sat_inc(snp_cnt_q);
                        default: begin
                            if (!mnt_op_q) begin
                                l1_cnt_d  = '0;
                                snp_cnt_d = '0;
                                ill_cnt_d = '0;
                                to_cnt_d  = '0;
                            end
                        end
                    endcase
                end else if (limit_hit_c) begin
                    // Abort: payload stays on the bus, only the valid drops.
                    state_d     = IDLE;
                    l1_valid_d  = 1'b0;
                    snp_valid_d = 1'b0;
                    mnt_valid_d = 1'b0;
                    to_pulse_d  = 1'b1;
                    to_cnt_d    = sat_inc(to_cnt_q);
                end else if (TIMEOUT != 0) begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            l1_valid_q  <= 1'b0;
            l1_op_q     <= '0;
            l1_addr_q   <= '0;
            snp_valid_q <= 1'b0;
            snp_op_q    <= '0;
            snp_addr_q  <= '0;
            mnt_valid_q <= 1'b0;
            mnt_op_q    <= 1'b0;
            tmr_q       <= '0;
            to_pulse_q  <= 1'b0;
            l1_cnt_q    <= '0;
            snp_cnt_q   <= '0;
            ill_cnt_q   <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            l1_valid_q  <= l1_valid_d;
            l1_op_q     <= l1_op_d;
            l1_addr_q   <= l1_addr_d;
            snp_valid_q <= snp_valid_d;
            snp_op_q    <= snp_op_d;
            snp_addr_q  <= snp_addr_d;
            mnt_valid_q <= mnt_valid_d;
            mnt_op_q    <= mnt_op_d;
            tmr_q       <= tmr_d;
            to_pulse_q  <= to_pulse_d;
            l1_cnt_q    <= l1_cnt_d;
            snp_cnt_q   <= snp_cnt_d;
            ill_cnt_q   <= ill_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign l1_req_valid  = l1_valid_q;
    assign l1_op         = l1_op_q;
    assign l1_addr       = l1_addr_q;
    assign snp_req_valid = snp_valid_q;
    assign snp_op        = snp_op_q;
    assign snp_addr      = snp_addr_q;
    assign mnt_req_valid = mnt_valid_q;
    assign mnt_op        = mnt_op_q;
    assign timeout_pulse = to_pulse_q;
    assign l1_count      = l1_cnt_q;
    assign snp_count     = snp_cnt_q;
    assign illegal_count = ill_cnt_q;
    assign timeout_count = to_cnt_q;

endmodule
